// File: rtl/switch_mcu_imem_ahb.sv
// rtl/switch_mcu_imem_ahb.sv - instruction memory AHB-Lite read slave with preload port
//
// Purpose: word-wide instruction memory for the switch MCU fetch unit. Filled
// through the load port after reset, then serves AHB single-word reads with
// WAIT_STATES wait cycles, and a two-cycle ERROR response to illegal requests.
//
// Ports:
//   in_clk, in_rst             clock, asynchronous active-high reset
//   in_load_valid/addr/data    load-port word write (LOAD state only)
//   in_load_last               final load word; leaves LOAD
//   out_init_done              high once loading has completed
//   in_hsel .. in_hmastlock    AHB-Lite request inputs (hburst/hport/hmastlock unused)
//   out_hready/hresp/hrdata    AHB-Lite response outputs
module switch_mcu_imem_ahb #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_load_valid,
  input  logic [ADDR_WIDTH-1:0] in_load_addr,
  input  logic [31:0]           in_load_data,
  input  logic                  in_load_last,
  output logic                  out_init_done,
  input  logic                  in_hsel,
  input  logic [31:0]           in_haddr,
  input  logic                  in_hwrite,
  input  logic [3:0]            in_hsize,
  input  logic [2:0]            in_hburst,
  input  logic [3:0]            in_hport,
  input  logic [1:0]            in_htrans,
  input  logic                  in_hmastlock,
  output logic                  out_hready,
  output logic                  out_hresp,
  output logic [31:0]           out_hrdata
);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Counter runs WAIT_STATES-1 down to 0, giving exactly WAIT_STATES cycles in WAIT.
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                state;
  state_t                state_nxt;
  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_index;
  logic [ADDR_WIDTH-1:0] req_index;
  logic [ADDR_WIDTH-1:0] fetch_index;
  logic [3:0]            wait_cnt;
  logic [31:0]           rdata;
  logic                  req_legal;
  logic                  addr_phase;
  logic                  accept_state;

  // Burst type, protection and lock carry no meaning for single-word fetches.
  logic unused_inputs;
  assign unused_inputs = ^{in_hburst, in_hport, in_hmastlock};

  assign req_index = in_haddr[ADDR_WIDTH+1:2];
  assign req_legal = !in_hwrite && (in_hsize == 4'd2) && (in_haddr[1:0] == 2'b00)
                     && (in_haddr[31:ADDR_WIDTH+2] == '0);

  // IDLE, DATA and ERR2 are the only states whose cycle ends with hready high
  // after loading, so they are the only places a new address phase can land.
  assign accept_state = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign addr_phase   = accept_state && in_hsel && (in_htrans != 2'b00);

  // With zero wait states the word is fetched straight from the address-phase
  // index; otherwise from the index captured at the address phase.
  assign fetch_index = (state == ST_WAIT) ? rd_index : req_index;

  always_comb begin
    state_nxt  = state;
    out_hready = 1'b1;
    out_hresp  = 1'b0;
    case (state)
      ST_LOAD: begin
        if (in_load_valid && in_load_last) state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        out_hready = 1'b0;
        if (wait_cnt == 4'd0) state_nxt = ST_DATA;
      end
      ST_ERR1: begin
        out_hready = 1'b0;
        out_hresp  = 1'b1;
        state_nxt  = ST_ERR2;
      end
      default: begin
        if (state == ST_ERR2) out_hresp = 1'b1;
        if (addr_phase) begin
          if (!req_legal)            state_nxt = ST_ERR1;
          else if (WAIT_STATES == 0) state_nxt = ST_DATA;
          else                       state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state    <= ST_LOAD;
      wait_cnt <= 4'd0;
      rd_index <= '0;
      rdata    <= 32'd0;
    end else begin
      state <= state_nxt;
      if (addr_phase && req_legal) rd_index <= req_index;
      if ((state_nxt == ST_WAIT) && (state != ST_WAIT)) wait_cnt <= WAIT_INIT;
      else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) wait_cnt <= wait_cnt - 4'd1;
      // Read data is latched on entry to DATA and then held until the next DATA.
      if (state_nxt == ST_DATA) rdata <= mem[fetch_index];
    end
  end

  // Memory contents survive reset so a reset alone does not lose the program.
  always_ff @(posedge in_clk) begin
    if ((state == ST_LOAD) && in_load_valid) mem[in_load_addr] <= in_load_data;
  end

  assign out_init_done = (state != ST_LOAD);
  assign out_hrdata    = rdata;

endmodule

// File: tb/tb_switch_mcu_imem_ahb.sv
// tb/tb_switch_mcu_imem_ahb.sv - randomized self-checking bench for switch_mcu_imem_ahb
module tb_switch_mcu_imem_ahb;

  localparam int NDUT  = 4;
  localparam int NLOAD = 64;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  size;
    logic [1:0]  trans;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic        load_last;

  logic        hsel_a      [NDUT];
  logic [31:0] haddr_a     [NDUT];
  logic        hwrite_a    [NDUT];
  logic [3:0]  hsize_a     [NDUT];
  logic [2:0]  hburst_a    [NDUT];
  logic [3:0]  hport_a     [NDUT];
  logic [1:0]  htrans_a    [NDUT];
  logic        hmastlock_a [NDUT];
  logic        hready_a    [NDUT];
  logic        hresp_a     [NDUT];
  logic        init_a      [NDUT];
  logic [31:0] hrdata_a    [NDUT];

  logic [31:0] model_mem [1024];
  logic [31:0] last_rd   [NDUT];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // One instance per wait-state setting 0..3.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    switch_mcu_imem_ahb #(.ADDR_WIDTH(10), .WAIT_STATES(g)) u_dut (
      .in_clk        (clk),
      .in_rst        (rst),
      .in_load_valid (load_valid),
      .in_load_addr  (load_addr),
      .in_load_data  (load_data),
      .in_load_last  (load_last),
      .out_init_done (init_a[g]),
      .in_hsel       (hsel_a[g]),
      .in_haddr      (haddr_a[g]),
      .in_hwrite     (hwrite_a[g]),
      .in_hsize      (hsize_a[g]),
      .in_hburst     (hburst_a[g]),
      .in_hport      (hport_a[g]),
      .in_htrans     (htrans_a[g]),
      .in_hmastlock  (hmastlock_a[g]),
      .out_hready    (hready_a[g]),
      .out_hresp     (hresp_a[g]),
      .out_hrdata    (hrdata_a[g])
    );
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(req_t r);
    return !r.write && (r.size == 4'd2) && (r.addr[1:0] == 2'b00) && (r.addr[31:12] == 20'd0);
  endfunction

  function automatic req_t mk(logic [31:0] a, logic w, logic [3:0] s);
    req_t r;
    r.addr = a; r.write = w; r.size = s; r.trans = 2'b01;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.write = 1'b0;
    r.size  = 4'd2;
    r.trans = 2'($urandom_range(1, 3));
    r.addr  = 32'($urandom_range(0, NLOAD - 1)) << 2;
    case ($urandom_range(0, 6))
      3: r.write = 1'b1;
      4: begin
        r.size = 4'($urandom_range(0, 15));
        if (r.size == 4'd2) r.size = 4'd3;
      end
      5: r.addr[1:0] = 2'($urandom_range(1, 3));
      6: r.addr[31:12] = 20'($urandom_range(1, 20'hFFFFF));
      default: ;
    endcase
    return r;
  endfunction

  task automatic drive_req(input int g, input req_t r);
    hsel_a[g]      = 1'b1;
    haddr_a[g]     = r.addr;
    hwrite_a[g]    = r.write;
    hsize_a[g]     = r.size;
    htrans_a[g]    = r.trans;
    hburst_a[g]    = 3'($urandom);
    hport_a[g]     = 4'($urandom);
    hmastlock_a[g] = 1'($urandom);
  endtask

  task automatic drive_noise(input int g);
    hsel_a[g]      = 1'($urandom);
    haddr_a[g]     = $urandom;
    hwrite_a[g]    = 1'($urandom);
    hsize_a[g]     = 4'($urandom);
    htrans_a[g]    = 2'($urandom);
    hburst_a[g]    = 3'($urandom);
    hport_a[g]     = 4'($urandom);
    hmastlock_a[g] = 1'($urandom);
  endtask

  task automatic drive_idle(input int g);
    drive_noise(g);
    if (1'($urandom)) hsel_a[g] = 1'b0;
    else              htrans_a[g] = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues the queue to DUT g (which inserts g wait states). Expected timing:
  // legal read -> g cycles hready=0, then one cycle hready=1 with the word;
  // illegal -> one cycle hready=0/hresp=1, then one cycle hready=1/hresp=1.
  task automatic run_seq(input int g, input req_t q[$], input bit all_b2b);
    logic [31:0] last;
    int          lat;
    bit          legal;
    bit          b2b;
    int          gap;
    last = last_rd[g];
    drive_req(g, q[0]);
    step();
    for (int t = 0; t < q.size(); t++) begin
      legal = is_legal(q[t]);
      lat   = legal ? g + 1 : 2;
      b2b   = (t + 1 < q.size()) && (all_b2b || 1'($urandom));
      for (int k = 1; k <= lat; k++) begin
        if (legal && k == lat) last = model_mem[q[t].addr[11:2]];
        check_val($sformatf("ws%0d xfer%0d cyc%0d hready", g, t, k), 32'(hready_a[g]), 32'(k == lat));
        check_val($sformatf("ws%0d xfer%0d cyc%0d hresp", g, t, k), 32'(hresp_a[g]), 32'(!legal));
        check_val($sformatf("ws%0d xfer%0d cyc%0d hrdata", g, t, k), hrdata_a[g], last);
        if (k < lat)  drive_noise(g);
        else if (b2b) drive_req(g, q[t+1]);
        else          drive_idle(g);
        step();
      end
      if (!b2b) begin
        gap = $urandom_range(0, 2);
        for (int i = 0; i <= gap; i++) begin
          check_val($sformatf("ws%0d idle%0d hready", g, t), 32'(hready_a[g]), 32'd1);
          check_val($sformatf("ws%0d idle%0d hresp", g, t), 32'(hresp_a[g]), 32'd0);
          check_val($sformatf("ws%0d idle%0d hrdata", g, t), hrdata_a[g], last);
          if (i == gap && t + 1 < q.size()) drive_req(g, q[t+1]);
          else                              drive_idle(g);
          step();
        end
      end
    end
    last_rd[g] = last;
  endtask

  initial begin
    req_t dq[$];
    req_t rq[$];
    int   idx;

    rst = 1'b0;
    load_valid = 1'b0; load_last = 1'b0; load_addr = '0; load_data = '0;
    for (int g = 0; g < NDUT; g++) begin
      drive_idle(g);
      last_rd[g] = 32'd0;
    end
    #2 rst = 1'b1;
    step();
    step();
    for (int g = 0; g < NDUT; g++) begin
      check_val($sformatf("ws%0d reset hready", g), 32'(hready_a[g]), 32'd1);
      check_val($sformatf("ws%0d reset hresp", g), 32'(hresp_a[g]), 32'd0);
      check_val($sformatf("ws%0d reset hrdata", g), hrdata_a[g], 32'd0);
      check_val($sformatf("ws%0d reset init_done", g), 32'(init_a[g]), 32'd0);
    end
    rst = 1'b0;

    model_mem[0] = 32'h00000013;
    model_mem[1] = 32'h00100093;
    model_mem[2] = 32'h00200113;
    model_mem[3] = 32'hDEADBEEF;
    for (int i = 4; i < NLOAD; i++) model_mem[i] = $urandom;

    // Load indices 4..63 first, then 0..3 with the last flag on index 3.
    // AHB requests are thrown at the slave throughout and must be ignored.
    for (int n = 0; n < NLOAD; n++) begin
      idx = (n < NLOAD - 4) ? n + 4 : n - (NLOAD - 4);
      if ($urandom_range(0, 3) == 0) begin
        load_valid = 1'b0; load_last = 1'($urandom); load_data = $urandom;
        for (int g = 0; g < NDUT; g++) drive_noise(g);
        step();
        for (int g = 0; g < NDUT; g++)
          check_val($sformatf("ws%0d bubble init_done", g), 32'(init_a[g]), 32'd0);
      end
      load_valid = 1'b1;
      load_addr  = 10'(idx);
      load_data  = model_mem[idx];
      load_last  = (n == NLOAD - 1);
      for (int g = 0; g < NDUT; g++) begin
        drive_req(g, rand_req());
        htrans_a[g] = 2'b01;
      end
      step();
      for (int g = 0; g < NDUT; g++) begin
        check_val($sformatf("ws%0d load%0d init_done", g, n), 32'(init_a[g]), 32'(n == NLOAD - 1));
        check_val($sformatf("ws%0d load%0d hready", g, n), 32'(hready_a[g]), 32'd1);
        check_val($sformatf("ws%0d load%0d hresp", g, n), 32'(hresp_a[g]), 32'd0);
        drive_idle(g);
      end
    end

    // Further load-port writes after init_done must not reach the memory.
    for (int n = 0; n < 3; n++) begin
      load_valid = 1'b1; load_addr = 10'(n); load_data = 32'hBADBAD00; load_last = 1'($urandom);
      step();
      check_val("post-load init_done", 32'(init_a[0]), 32'd1);
    end
    load_valid = 1'b0;

    dq.delete();
    dq.push_back(mk(32'h4, 1'b0, 4'd2));
    dq.push_back(mk(32'h8, 1'b0, 4'd2));
    dq.push_back(mk(32'hC, 1'b0, 4'd2));
    dq.push_back(mk(32'h0, 1'b1, 4'd2));
    dq.push_back(mk(32'h2, 1'b0, 4'd2));
    dq.push_back(mk(32'h1000, 1'b0, 4'd2));
    dq.push_back(mk(32'h0, 1'b0, 4'd2));
    dq.push_back(mk(32'h0, 1'b0, 4'd2));
    dq.push_back(mk(32'h4, 1'b0, 4'd2));
    dq.push_back(mk(32'h8, 1'b0, 4'd2));
    for (int g = 0; g < NDUT; g++) begin
      run_seq(g, dq, 1'b1);
      rq.delete();
      for (int i = 0; i < 40; i++) rq.push_back(rand_req());
      run_seq(g, rq, 1'b0);
    end

    // Reset while the 3-wait-state slave is in its wait phase.
    drive_req(3, mk(32'h4, 1'b0, 4'd2));
    step();
    check_val("ws3 pre-reset hready", 32'(hready_a[3]), 32'd0);
    drive_idle(3);
    #2 rst = 1'b1;
    #1;
    check_val("ws3 mid-reset hready", 32'(hready_a[3]), 32'd1);
    check_val("ws3 mid-reset hresp", 32'(hresp_a[3]), 32'd0);
    check_val("ws3 mid-reset hrdata", hrdata_a[3], 32'd0);
    check_val("ws3 mid-reset init_done", 32'(init_a[3]), 32'd0);
    step();
    rst = 1'b0;
    for (int g = 0; g < NDUT; g++) last_rd[g] = 32'd0;

    for (int n = 0; n < 4; n++) begin
      for (int g = 0; g < NDUT; g++) drive_req(g, mk(32'h4, 1'b0, 4'd2));
      step();
      for (int g = 0; g < NDUT; g++) begin
        check_val($sformatf("ws%0d reload-wait hready", g), 32'(hready_a[g]), 32'd1);
        check_val($sformatf("ws%0d reload-wait hresp", g), 32'(hresp_a[g]), 32'd0);
        check_val($sformatf("ws%0d reload-wait hrdata", g), hrdata_a[g], 32'd0);
        check_val($sformatf("ws%0d reload-wait init_done", g), 32'(init_a[g]), 32'd0);
      end
    end

    model_mem[5] = $urandom;
    load_valid = 1'b1; load_last = 1'b1; load_addr = 10'd5; load_data = model_mem[5];
    for (int g = 0; g < NDUT; g++) drive_idle(g);
    step();
    load_valid = 1'b0; load_last = 1'b0;
    for (int g = 0; g < NDUT; g++)
      check_val($sformatf("ws%0d reload init_done", g), 32'(init_a[g]), 32'd1);

    dq.delete();
    dq.push_back(mk(32'h0, 1'b0, 4'd2));
    dq.push_back(mk(32'h14, 1'b0, 4'd2));
    dq.push_back(mk(32'hC, 1'b0, 4'd2));
    for (int g = 0; g < NDUT; g++) run_seq(g, dq, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
